// File: rtl/store_size_rmw_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : store_size_rmw_pkg
//  Purpose  : Shared encodings for the narrowing store unit.
//             - Store-size codes, also used by the control-unit decode.
//             - FSM state encodings.
//             - Alignment-check helper.
//  Revision : 1.0  initial release
// ============================================================================
package store_size_rmw_pkg;

    // Store-size encodings
    localparam logic [1:0] SIZE_WORD = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_BYTE = 2'b10;
    localparam logic [1:0] SIZE_RSVD = 2'b11;

    // FSM state encodings
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_READ  = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Returns 1 when a store of the given size cannot be issued at this byte
    // offset. The reserved size code is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size,
                                           input logic [1:0] offset);
        logic bad;
        bad = 1'b1;
        case (size)
            SIZE_WORD: bad = (offset != 2'b00);
            SIZE_HALF: bad = offset[0];
            SIZE_BYTE: bad = 1'b0;
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage
`default_nettype wire

// File: rtl/store_size_rmw_lane_merge.sv
`default_nettype none
// ============================================================================
//  Module   : store_lane_merge
//  Purpose  : Combinational big-endian lane merge for narrow stores.
//             Replaces the addressed byte/half lane of old_word with the low
//             bits of new_data; every other lane keeps the old contents.
//  Ports    : old_word [31:0] in  - word read back from memory
//             new_data [31:0] in  - register value (only low 8/16 bits used
//                                   for byte/half stores)
//             size     [1:0]  in  - store-size code
//             offset   [1:0]  in  - byte offset within the word
//             merged   [31:0] out - word to write back
//  Revision : 1.0  initial release
// ============================================================================
module store_lane_merge
    import store_size_rmw_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] new_data,
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    output logic [31:0] merged
);

    // Big-endian lanes: byte offset 0 is the most significant byte.
    always_comb begin
        merged = old_word;
        case (size)
            SIZE_WORD: merged = new_data;
            SIZE_HALF: begin
                if (offset[1] == 1'b0) merged[31:16] = new_data[15:0];
                else                   merged[15:0]  = new_data[15:0];
            end
            SIZE_BYTE: begin
                case (offset)
                    2'd0:    merged[31:24] = new_data[7:0];
                    2'd1:    merged[23:16] = new_data[7:0];
                    2'd2:    merged[15:8]  = new_data[7:0];
                    default: merged[7:0]   = new_data[7:0];
                endcase
            end
            default: merged = old_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/store_size_rmw.sv
`default_nettype none
// ============================================================================
//  Module   : store_size_rmw
//  Purpose  : Narrowing store unit for the multicycle MIPS datapath.
//             SW writes the full word; SH/SB read the addressed word, merge
//             the truncated register value into its lane and write it back.
//  Params   : MEM_LAT     - data-memory read latency in cycles (>= 1)
//  Ports    : clk         in   clock, rising edge
//             reset       in   asynchronous active-high reset
//             start       in   request strobe, sampled only when idle
//             size  [1:0] in   00 word, 01 half, 10 byte, 11 reserved
//             addr  [31:0] in  byte address of the store
//             wdata [31:0] in  register value
//             busy        out  operation in progress (accept+1 .. done)
//             done        out  one-cycle completion / rejection pulse
//             misaligned  out  valid with done; store was rejected
//             mem_addr [31:0] out word address, stable while busy
//             mem_rd      out  one-cycle read strobe
//             mem_wr      out  one-cycle write strobe
//             mem_wdata [31:0] out merged word, valid with mem_wr
//             mem_rdata [31:0] in  memory read data
//  Revision : 1.0  initial release
// ============================================================================
module store_size_rmw
    import store_size_rmw_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        misaligned,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    localparam int                c_CNT_W    = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_LAT - 1);

    logic [2:0]         r_state;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [1:0]         r_size;
    logic [1:0]         r_offset;
    logic [31:0]        r_wdata;
    logic               r_busy;
    logic               r_done;
    logic               r_misaligned;
    logic [31:0]        r_mem_addr;
    logic               r_mem_rd;
    logic               r_mem_wr;
    logic [31:0]        r_mem_wdata;

    logic [2:0]         w_state_next;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               w_accept;
    logic               w_err;
    logic               w_last_wait;
    logic [31:0]        w_merged;

    // Merge works straight off the memory bus so the merged word can be
    // captured on the last WAIT cycle, the only cycle rdata is guaranteed.
    store_lane_merge u_merge (
        .old_word (mem_rdata),
        .new_data (r_wdata),
        .size     (r_size),
        .offset   (r_offset),
        .merged   (w_merged)
    );

    assign w_err       = is_misaligned(size, addr[1:0]);
    assign w_last_wait = (r_state == ST_WAIT) && (r_wait_cnt == c_CNT_LAST);

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_wait_cnt;
        w_accept     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (w_err)                   w_state_next = ST_DONE;
                    else if (size == SIZE_WORD)  w_state_next = ST_WRITE;
                    else                         w_state_next = ST_READ;
                end
            end
            ST_READ: begin
                w_state_next = ST_WAIT;
                w_cnt_next   = '0;
            end
            ST_WAIT: begin
                if (w_last_wait) w_state_next = ST_WRITE;
                else             w_cnt_next   = r_wait_cnt + c_CNT_W'(1);
            end
            ST_WRITE: w_state_next = ST_DONE;
            ST_DONE:  w_state_next = ST_IDLE;
            default:  w_state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so each strobe lines up
    // exactly with the state it belongs to.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_wait_cnt   <= '0;
            r_size       <= SIZE_WORD;
            r_offset     <= 2'b00;
            r_wdata      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_misaligned <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_wait_cnt   <= w_cnt_next;
            r_busy       <= (w_state_next != ST_IDLE);
            r_done       <= (w_state_next == ST_DONE);
            r_mem_rd     <= (w_state_next == ST_READ);
            r_mem_wr     <= (w_state_next == ST_WRITE);
            r_misaligned <= w_accept && w_err;
            if (w_accept) begin
                r_size     <= size;
                r_offset   <= addr[1:0];
                r_wdata    <= wdata;
                r_mem_addr <= {addr[31:2], 2'b00};
                if (!w_err && (size == SIZE_WORD)) r_mem_wdata <= wdata;
            end
            if (w_last_wait) r_mem_wdata <= w_merged;
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign misaligned = r_misaligned;
    assign mem_addr   = r_mem_addr;
    assign mem_rd     = r_mem_rd;
    assign mem_wr     = r_mem_wr;
    assign mem_wdata  = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_store_size_rmw.sv
`default_nettype none
// ============================================================================
//  Module   : tb_store_size_rmw
//  Purpose  : Scoreboard bench for store_size_rmw. Two instances are used:
//             u_dut_a with MEM_LAT=1 and u_dut_b with MEM_LAT=3. Directed
//             stores push their hand-computed memory events into a queue; a
//             negedge monitor pops and compares every mem_rd/mem_wr/done.
//  Revision : 1.0  initial release
// ============================================================================
module tb_store_size_rmw;

    localparam int K_RD   = 0;
    localparam int K_WR   = 1;
    localparam int K_DONE = 2;

    typedef struct {
        int          dut;
        int          kind;
        int          cyc;
        logic [31:0] addr;
        logic [31:0] data;
        logic        mis;
    } ev_t;

    ev_t exp_q[$];
    int  compared   = 0;
    int  mismatched = 0;
    int  cyc        = 0;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    logic        start_a = 1'b0, start_b = 1'b0;
    logic [1:0]  size_a  = 2'b00, size_b = 2'b00;
    logic [31:0] addr_a  = '0, addr_b = '0;
    logic [31:0] wdata_a = '0, wdata_b = '0;
    logic [31:0] mem_rdata_a = '0, mem_rdata_b = '0;
    logic        busy_a, done_a, mis_a, mem_rd_a, mem_wr_a;
    logic        busy_b, done_b, mis_b, mem_rd_b, mem_wr_b;
    logic [31:0] mem_addr_a, mem_wdata_a, mem_addr_b, mem_wdata_b;

    logic [31:0] mem_word = '0;
    int          rd_cyc_a = -100;
    int          rd_cyc_b = -100;

    store_size_rmw #(.MEM_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .size(size_a),
        .addr(addr_a), .wdata(wdata_a), .busy(busy_a), .done(done_a),
        .misaligned(mis_a), .mem_addr(mem_addr_a), .mem_rd(mem_rd_a),
        .mem_wr(mem_wr_a), .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a)
    );

    store_size_rmw #(.MEM_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .size(size_b),
        .addr(addr_b), .wdata(wdata_b), .busy(busy_b), .done(done_b),
        .misaligned(mis_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
        .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is valid only in the cycle exactly MEM_LAT
    // cycles after the read strobe; otherwise a poison pattern is driven.
    always @(negedge clk) begin
        if (mem_rd_a) rd_cyc_a = cyc;
        if (mem_rd_b) rd_cyc_b = cyc;
    end

    always @(posedge clk) begin
        #1;
        mem_rdata_a = (cyc == rd_cyc_a + 1) ? mem_word : 32'hBAD0_BAD0;
        mem_rdata_b = (cyc == rd_cyc_b + 3) ? mem_word : 32'hBAD0_BAD0;
    end

    function automatic string kname(input int k);
        if (k == K_RD) return "mem_rd";
        if (k == K_WR) return "mem_wr";
        return "done";
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic observe(input int d, input int k, input logic [31:0] a,
                           input logic [31:0] w, input logic m);
        ev_t e;
        compared++;
        if (exp_q.size() == 0 || exp_q[0].dut != d || exp_q[0].kind != k ||
            exp_q[0].cyc != cyc) begin
            mismatched++;
            $display("FAIL unexpected_%s dut%0d: event at cycle %0d, required none",
                     kname(k), d, cyc);
        end else begin
            e = exp_q.pop_front();
            if ((k != K_DONE && a !== e.addr) || (k == K_WR && w !== e.data) ||
                (k == K_DONE && m !== e.mis)) begin
                mismatched++;
                $display("FAIL %s dut%0d cycle %0d: got addr=%h data=%h mis=%0b, required addr=%h data=%h mis=%0b",
                         kname(k), d, cyc, a, w, m, e.addr, e.data, e.mis);
            end
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            compared++;
            mismatched++;
            $display("FAIL missing_%s dut%0d: nothing by cycle %0d, required at cycle %0d",
                     kname(exp_q[0].kind), exp_q[0].dut, cyc, exp_q[0].cyc);
            void'(exp_q.pop_front());
        end
        if (mem_rd_a) observe(0, K_RD,   mem_addr_a, mem_wdata_a, mis_a);
        if (mem_wr_a) observe(0, K_WR,   mem_addr_a, mem_wdata_a, mis_a);
        if (done_a)   observe(0, K_DONE, mem_addr_a, mem_wdata_a, mis_a);
        if (mem_rd_b) observe(1, K_RD,   mem_addr_b, mem_wdata_b, mis_b);
        if (mem_wr_b) observe(1, K_WR,   mem_addr_b, mem_wdata_b, mis_b);
        if (done_b)   observe(1, K_DONE, mem_addr_b, mem_wdata_b, mis_b);
    end

    task automatic drive(input int d, input logic s, input logic [1:0] sz,
                         input logic [31:0] ad, input logic [31:0] wd);
        if (d == 0) begin
            start_a = s; size_a = sz; addr_a = ad; wdata_a = wd;
        end else begin
            start_b = s; size_b = sz; addr_b = ad; wdata_b = wd;
        end
    endtask

    task automatic push(input int d, input int k, input int c,
                        input logic [31:0] a, input logic [31:0] w, input logic m);
        ev_t e;
        e.dut = d; e.kind = k; e.cyc = c; e.addr = a; e.data = w; e.mis = m;
        exp_q.push_back(e);
    endtask

    // mode 0: normal; 1: keep start high with junk operands until done;
    // 2: store will be abandoned by reset after the read strobe.
    task automatic issue(input int d, input logic [1:0] sz, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [31:0] md,
                         input logic [31:0] exp_word, input logic exp_mis,
                         input int mode);
        int          lat;
        int          c0;
        int          done_off;
        int          n;
        logic [31:0] wa;
        lat      = (d == 0) ? 1 : 3;
        c0       = cyc;
        wa       = {ad[31:2], 2'b00};
        mem_word = md;
        if (exp_mis) begin
            push(d, K_DONE, c0 + 1, 32'h0, 32'h0, 1'b1);
            done_off = 1;
        end else if (sz == 2'b00) begin
            push(d, K_WR,   c0 + 1, wa, exp_word, 1'b0);
            push(d, K_DONE, c0 + 2, 32'h0, 32'h0, 1'b0);
            done_off = 2;
        end else begin
            push(d, K_RD, c0 + 1, wa, 32'h0, 1'b0);
            if (mode != 2) begin
                push(d, K_WR,   c0 + 2 + lat, wa, exp_word, 1'b0);
                push(d, K_DONE, c0 + 3 + lat, 32'h0, 32'h0, 1'b0);
            end
            done_off = 3 + lat;
        end
        drive(d, 1'b1, sz, ad, wd);
        @(posedge clk); #1;
        if (mode == 1) begin
            drive(d, 1'b1, 2'b00, 32'h0000_0300, 32'hFFFF_FFFF);
            repeat (done_off) begin @(posedge clk); #1; end
        end
        drive(d, 1'b0, 2'b00, 32'h0, 32'h0);
        if (mode != 2) begin
            n = 0;
            while (exp_q.size() != 0 && n < 30) begin
                @(posedge clk); #1;
                n++;
            end
            if (exp_q.size() != 0) begin
                compared++;
                mismatched++;
                $display("FAIL timeout dut%0d: %0d events outstanding, required 0",
                         d, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy",       {31'b0, busy_a},   32'h0);
        chk("reset_done",       {31'b0, done_a},   32'h0);
        chk("reset_misaligned", {31'b0, mis_a},    32'h0);
        chk("reset_mem_rd",     {31'b0, mem_rd_a}, 32'h0);
        chk("reset_mem_wr",     {31'b0, mem_wr_a}, 32'h0);
        chk("reset_mem_addr",   mem_addr_a,        32'h0);
        chk("reset_mem_wdata",  mem_wdata_a,       32'h0);
        chk("reset_busy_b",     {31'b0, busy_b},   32'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Word store
        issue(0, 2'b00, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        32'hDEAD_BEEF, 1'b0, 0);
        // Byte stores across all four big-endian lanes
        issue(0, 2'b10, 32'h0000_0203, 32'h1234_56AB, 32'h1122_3344, 32'h1122_33AB, 1'b0, 0);
        issue(0, 2'b10, 32'h0000_0200, 32'h0000_00CD, 32'h1122_3344, 32'hCD22_3344, 1'b0, 0);
        issue(0, 2'b10, 32'h0000_0201, 32'h0000_00CD, 32'h1122_3344, 32'h11CD_3344, 1'b0, 0);
        issue(0, 2'b10, 32'h0000_0202, 32'h0000_00CD, 32'h1122_3344, 32'h1122_CD44, 1'b0, 0);
        // Half stores, both lanes
        issue(0, 2'b01, 32'h0000_0200, 32'hFFFF_8001, 32'hAAAA_BBBB, 32'h8001_BBBB, 1'b0, 0);
        issue(0, 2'b01, 32'h0000_0202, 32'hFFFF_8001, 32'hAAAA_BBBB, 32'hAAAA_8001, 1'b0, 0);
        // Rejected stores
        issue(0, 2'b01, 32'h0000_0201, 32'h1111_2222, 32'h0, 32'h0, 1'b1, 0);
        issue(0, 2'b00, 32'h0000_0102, 32'h3333_4444, 32'h0, 32'h0, 1'b1, 0);
        issue(0, 2'b11, 32'h0000_0100, 32'h5555_6666, 32'h0, 32'h0, 1'b1, 0);

        // Longer memory latency with start held high throughout busy/done
        issue(1, 2'b10, 32'h0000_0200, 32'h0000_005A, 32'h0102_0304, 32'h5A02_0304, 1'b0, 1);
        issue(1, 2'b01, 32'h0000_0202, 32'h0000_BEEF, 32'h0102_0304, 32'h0102_BEEF, 1'b0, 0);

        // Reset in the middle of a byte store
        issue(0, 2'b10, 32'h0000_0203, 32'h0000_0077, 32'h1122_3344, 32'h0, 1'b0, 2);
        @(posedge clk); #1;
        chk("abort_busy_before_reset", {31'b0, busy_a}, 32'h1);
        reset = 1'b1;
        #1;
        chk("abort_busy",   {31'b0, busy_a},   32'h0);
        chk("abort_mem_rd", {31'b0, mem_rd_a}, 32'h0);
        chk("abort_mem_wr", {31'b0, mem_wr_a}, 32'h0);
        chk("abort_done",   {31'b0, done_a},   32'h0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        issue(0, 2'b00, 32'h0000_0104, 32'h1357_9BDF, 32'h0, 32'h1357_9BDF, 1'b0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
`default_nettype wire
